// File: rtl/micro_ucr_hash_arbiter.sv
// micro_ucr_hash_arbiter: round-robin sharing of one hash engine
// between N_REQ requesters, with a watchdog on each transaction.
module micro_ucr_hash_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*128-1:0] req_block,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic               rsp_err,
    output logic [23:0]        rsp_hash,
    output logic               busy,
    output logic               hash_init,
    output logic               hash_valid,
    output logic [127:0]       hash_block,
    input  logic [23:0]        hash,
    input  logic               hash_ready
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel_q;
    logic [PW-1:0]   sel_c;
    logic            any_req;
    logic [15:0]     cnt;
    int              idx;

    // Round-robin pick: lowest offset from ptr wins (loop runs high to low)
    always_comb begin
        sel_c   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) begin
                sel_c   = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; ready wins over the watchdog in the same cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (any_req) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (hash_ready || cnt == TO_LAST) state_nx = RESP;
            RESP:  state_nx = IDLE;
        endcase
    end

    // Transaction datapath: grant capture, watchdog, result capture, pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            sel_q      <= '0;
            cnt        <= '0;
            gnt        <= '0;
            hash_block <= '0;
            rsp_hash   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_q      <= sel_c;
                        gnt        <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_c;
                        hash_block <= req_block[int'(sel_c)*128 +: 128];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (hash_ready) begin
                        rsp_hash <= hash;
                        rsp_err  <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        rsp_hash <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    gnt <= '0;
                    ptr <= (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                end
            endcase
        end
    end

    // State-decoded outputs so reset clears them immediately
    always_comb begin
        busy       = (state != IDLE);
        hash_init  = (state == ISSUE);
        hash_valid = (state == ISSUE) || (state == WAIT);
        rsp_valid  = (state == RESP) ? gnt : '0;
    end

endmodule

// File: tb/tb_micro_ucr_hash_arbiter.sv
// tb_micro_ucr_hash_arbiter: directed scoreboard bench with a stub
// hash engine answering LAT cycles after each start pulse.
module tb_micro_ucr_hash_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*128-1:0] req_block;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic           rsp_err;
    logic [23:0]    rsp_hash;
    logic           busy;
    logic           hash_init;
    logic           hash_valid;
    logic [127:0]   hash_block;
    logic [23:0]    hash = '0;
    logic           hash_ready = 1'b0;
    bit             stuck = 1'b0;

    logic [127:0]   blk [N];
    logic [23:0]    hval [N];
    logic [28:0]    q [$];
    int             n_cmp = 0;
    int             n_bad = 0;

    assign req_block = {blk[3], blk[2], blk[1], blk[0]};

    always #5 clk = ~clk;

    micro_ucr_hash_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_block(req_block),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_hash(rsp_hash), .busy(busy), .hash_init(hash_init),
        .hash_valid(hash_valid), .hash_block(hash_block),
        .hash(hash), .hash_ready(hash_ready)
    );

    task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // Monitor: every response pulse is matched against the queue head
    always @(negedge clk) begin
        if (!reset && rsp_valid != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                logic [28:0] e;
                e = q.pop_front();
                chk("rsp_valid", 128'(rsp_valid), 128'(e[28:25]));
                chk("rsp_hash", 128'(rsp_hash), 128'(e[24:1]));
                chk("rsp_err", 128'(rsp_err), 128'(e[0]));
            end
        end
    end

    // Stub engine: checks the launched block, answers after LAT cycles
    initial begin
        forever begin
            @(negedge clk);
            if (hash_init === 1'b1 && !reset) begin
                int k;
                k = 0;
                for (int j = 0; j < N; j++) if (gnt[j]) k = j;
                chk("blk_at_init", hash_block, blk[k]);
                if (!stuck) begin
                    repeat (LAT) @(posedge clk);
                    #1;
                    hash = hval[k];
                    hash_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    hash_ready = 1'b0;
                    hash = 24'hEEEEEE;
                end
            end
        end
    end

    task automatic push(logic [3:0] v, logic [23:0] h, logic e);
        q.push_back({v, h, e});
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(logic [3:0] m, int budget);
        req = m;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        req = '0;
        drain(budget);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL global_timeout: got running want done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        blk[0] = {32'h0, 96'hf3000817_03000021_70636961};
        blk[1] = {32'h1, 96'h11111111_22222222_33333333};
        blk[2] = {32'h2, 96'hdeadbeef_cafef00d_01020304};
        blk[3] = {32'h3, 96'h0badc0de_55aa55aa_a5a5a5a5};
        hval[0] = 24'h0A1B2C;
        hval[1] = 24'h5A5A5A;
        hval[2] = 24'h000102;
        hval[3] = 24'hC3C3C3;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 128'(gnt), 0);
        chk("rst_rsp_valid", 128'(rsp_valid), 0);
        chk("rst_rsp_err", 128'(rsp_err), 0);
        chk("rst_rsp_hash", 128'(rsp_hash), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_hash_init", 128'(hash_init), 0);
        chk("rst_hash_valid", 128'(hash_valid), 0);
        chk("rst_hash_block", hash_block, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester with cycle-level checks
        push(4'b0001, 24'h0A1B2C, 1'b0);
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("c1_gnt", 128'(gnt), 128'(4'b0001));
        chk("c1_hash_init", 128'(hash_init), 1);
        chk("c1_busy", 128'(busy), 1);
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        chk("c2_hash_init", 128'(hash_init), 0);
        chk("c2_hash_valid", 128'(hash_valid), 1);
        repeat (5) @(negedge clk);
        chk("c7_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
        @(negedge clk);
        chk("c8_busy", 128'(busy), 0);
        chk("c8_gnt", 128'(gnt), 0);
        chk("c8_hash_valid", 128'(hash_valid), 0);
        @(posedge clk);
        #1;

        // Simultaneous requests from reset: 1 then 3
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(4'b0010, hval[1], 1'b0);
        push(4'b1000, hval[3], 1'b0);
        req = 4'b1010;
        drain(100);
        req = '0;
        repeat (2) @(posedge clk);
        #1;

        // Fairness: all four requesting for 8 transactions
        for (int r = 0; r < 8; r++) begin
            logic [3:0] m;
            m = 4'b0001 << (r % 4);
            push(m, hval[r % 4], 1'b0);
        end
        req = 4'b1111;
        drain(300);
        req = '0;
        repeat (2) @(posedge clk);
        #1;

        // Watchdog: engine never answers
        stuck = 1'b1;
        push(4'b0100, 24'h0, 1'b1);
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        chk("wd_hash_init", 128'(hash_init), 1);
        @(posedge clk);
        #1;
        req = '0;
        n = 0;
        while (rsp_valid == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wd_latency", 128'(n), 128'(TO + 1));
        chk("wd_err_level", 128'(rsp_err), 1);
        @(posedge clk);
        #1;
        stuck = 1'b0;
        push(4'b1000, hval[3], 1'b0);
        txn(4'b1000, 60);

        // Reset mid-WAIT with ptr away from 0
        push(4'b0010, hval[1], 1'b0);
        txn(4'b0010, 60);
        req = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        chk("rw_gnt", 128'(gnt), 128'(4'b0100));
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_gnt0", 128'(gnt), 0);
        chk("rw_busy", 128'(busy), 0);
        chk("rw_hash_valid", 128'(hash_valid), 0);
        chk("rw_rsp_valid", 128'(rsp_valid), 0);
        chk("rw_rsp_hash", 128'(rsp_hash), 0);
        chk("rw_hash_block", hash_block, 0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        push(4'b0010, hval[1], 1'b0);
        txn(4'b0110, 60);

        // Request dropped mid-transaction still gets its response
        push(4'b0100, 24'h000102, 1'b0);
        txn(4'b0100, 60);

        repeat (3) @(posedge clk);
        chk("q_empty", 128'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_ucr_hash_arbiter.md
# micro_ucr_hash_arbiter

Round-robin arbiter and sequencer that shares one `micro_ucr_hash` engine between `N_REQ` nonce-search requesters, for example several `system`-style miners. It owns the engine's `hash_init`, `valid` and `block_in` inputs, and runs one transaction at a time: grant, launch, wait for `hash_ready`, return the hash. A watchdog aborts any transaction whose engine result never arrives. The block sits between the requesters and the single hash instance in the top level.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1023: maximum WAIT cycles before abort, 1..65535.

Ports:
- `clk` input, 1: system clock, rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state.
- `req` input, N_REQ: per-requester request level.
- `req_block` input, N_REQ*128: requester i's 128-bit `{nonce, bytes}` in bits [i*128 +: 128].
- `gnt` output, N_REQ: one-hot grant, held for the whole transaction.
- `rsp_valid` output, N_REQ: one-cycle pulse to the granted requester.
- `rsp_err` output, 1: qualifies `rsp_valid`; 1 = watchdog abort.
- `rsp_hash` output, 24: captured engine hash, valid while `rsp_valid` is set.
- `busy` output, 1: high in every state except IDLE.
- `hash_init` output, 1: engine start pulse.
- `hash_valid` output, 1: engine `valid` input.
- `hash_block` output, 128: engine `block_in`.
- `hash` input, 24: engine hash output.
- `hash_ready` input, 1: engine done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `req != 0`, pick the first set bit scanning upward from `ptr`, wrapping modulo N_REQ.
  - Register that requester's `req_block` into `hash_block`, set `gnt[sel]`, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `hash_init=1` and `hash_valid=1` for exactly one cycle.
  - Clear the watchdog counter, go to WAIT.
- WAIT:
  - `hash_init=0`; `hash_valid` stays 1.
  - The watchdog counter increments every cycle.
  - On `hash_ready=1`: capture `hash` into `rsp_hash`, set `rsp_err=0`, go to RESP.
  - Else, when the counter reaches TIMEOUT-1: set `rsp_hash=0` and `rsp_err=1`, go to RESP.
  - `hash_ready` takes priority over timeout in the same cycle.
- RESP:
  - `rsp_valid[sel]=1` for one cycle.
  - Update `ptr` to (sel+1) mod N_REQ.
  - Clear `gnt` and `hash_valid`, go to IDLE.
- `hash_block` holds its value until the next grant. `rsp_hash` and `rsp_err` hold until the next RESP.
- `hash_ready` seen outside WAIT is ignored.
- Deasserting `req[sel]` mid-transaction does not abort. The transaction completes and `rsp_valid[sel]` still pulses.
- `req_block` is sampled only at grant, so later changes are ignored. A requester may re-request in the cycle after its `rsp_valid`.
- After an abort, the next ISSUE `hash_init` pulse restarts the engine. No other engine recovery is attempted.
- The watchdog counter is 16 bits and does not wrap before TIMEOUT.
- `ptr` width is clog2(N_REQ) and wraps modulo N_REQ. With N_REQ not a power of two, out-of-range values never occur.

## Timing
- Reset values:
  - All outputs are 0: `gnt`, `rsp_valid`, `rsp_err`, `rsp_hash`, `busy`, `hash_init`, `hash_valid`, `hash_block`.
  - `ptr=0`, counter=0, state=IDLE.
- Reset mid-transaction returns to IDLE immediately. No `rsp_valid` is issued and `ptr` returns to 0.
- Cycle numbering, from the cycle in which `req` is sampled high in IDLE:
  - cycle 0: request sampled in IDLE.
  - cycle 1: `gnt` and `hash_block` valid; ISSUE with `hash_init` high.
  - cycle 2: enter WAIT.
  - cycle R: `hash_ready` high in WAIT.
  - cycle R+1: RESP, with `rsp_valid` and `rsp_hash` valid.
  - cycle R+2: IDLE, `gnt` low.
- Overhead is 3 cycles plus engine latency.
- Back-to-back: a request pending at R+2 gets a grant at R+3.
- Timeout: RESP occurs TIMEOUT cycles after WAIT entry.

## Test plan
- Single requester:
  - Stimulus: N_REQ=4, req=0001, block = `{32'h0, 96'hf3000817_03000021_70636961}`, stub engine returns 24'h0A1B2C after 5 WAIT cycles.
  - Response: `gnt=0001` at cycle 1, `hash_init` one pulse, `rsp_valid=0001` with `rsp_hash=0A1B2C`, `rsp_err=0`, `busy` low at R+2.
- Simultaneous requests:
  - Stimulus: req=1010 from reset.
  - Response: grant order is 1, then 3; each gets its own captured block on `hash_block`.
- Round-robin fairness:
  - Stimulus: req=1111 held for 8 transactions.
  - Response: grant sequence 0,1,2,3,0,1,2,3; no requester is served twice in a row.
- Watchdog:
  - Stimulus: TIMEOUT=16, `hash_ready` stuck at 0.
  - Response: RESP exactly 16 cycles after WAIT entry with `rsp_err=1`, `rsp_hash=0`. The next request proceeds normally.
- Reset mid-WAIT:
  - Stimulus: assert `reset` asynchronously between edges during WAIT.
  - Response: all outputs 0 immediately, no `rsp_valid`; the next grant starts from `ptr=0`.
- Request dropped:
  - Stimulus: `req[2]` deasserted in cycle 2; engine later returns 24'h000102.
  - Response: `rsp_valid=0100` still pulses with `rsp_hash=000102`.
